// File: rtl/adder_bist_pkg.sv
// Shared types, width helpers and the reference adder for the adder BIST controller.
package adder_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Reference adder is evaluated at this width and truncated by the user to N+1 bits.
  localparam int unsigned MAX_BITS = 32;

  function automatic int unsigned calc_vec_w(input int unsigned n);
    return 2 * n + 1;
  endfunction

  function automatic int unsigned calc_err_w(input int unsigned n);
    return 2 * n + 2;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned settle);
    return (settle <= 1) ? 1 : $clog2(settle);
  endfunction

  localparam int unsigned NUM_BITS_DEF = 4;
  localparam int unsigned VEC_W_DEF    = calc_vec_w(NUM_BITS_DEF);
  localparam int unsigned ERR_W_DEF    = calc_err_w(NUM_BITS_DEF);

  function automatic logic [MAX_BITS:0] adder_ref(input logic [MAX_BITS-1:0] a,
                                                  input logic [MAX_BITS-1:0] b,
                                                  input logic                cin);
    return {1'b0, a} + {1'b0, b} + (MAX_BITS + 1)'(cin);
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Adder stimulus/response bus plus run control and result signals of the BIST.
interface adder_bist_if
  import adder_bist_pkg::*;
#(
  parameter int unsigned NUM_BITS = 4
);
  localparam int unsigned VEC_W = calc_vec_w(NUM_BITS);
  localparam int unsigned ERR_W = calc_err_w(NUM_BITS);

  logic                start;
  logic [NUM_BITS-1:0] a_out;
  logic [NUM_BITS-1:0] b_out;
  logic                carry_in_out;
  logic [NUM_BITS-1:0] sum_in;
  logic                carry_out_in;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    error_count;
  logic [VEC_W-1:0]    first_fail_vector;
  logic                first_fail_valid;

  // BIST controller side
  modport master (
    input  start, sum_in, carry_out_in,
    output a_out, b_out, carry_in_out, busy, done, pass,
           error_count, first_fail_vector, first_fail_valid
  );

  // Adder under test and run requester side
  modport slave (
    output start, sum_in, carry_out_in,
    input  a_out, b_out, carry_in_out, busy, done, pass,
           error_count, first_fail_vector, first_fail_valid
  );

endinterface

// File: rtl/adder_bist_flex_counter.sv
// Wrapping up-counter 0..rollover_val with a registered flag high while count equals rollover_val.
module adder_bist_flex_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             count_enable_i,
  input  logic [WIDTH-1:0] rollover_val_i,
  output logic             rollover_flag_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      count_d = (count_q == rollover_val_i) ? '0 : count_q + WIDTH'(1);
    end
    // Flag tracks the next count so it is valid from the first cycle after a clear.
    flag_d = (count_d == rollover_val_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign rollover_flag_o = flag_q;

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test controller for an N-bit combinational adder.
// Optional ADDER_BIST_STOP_ON_FAIL_EN ends the run on the first mismatching vector.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned NUM_BITS      = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  adder_bist_if.master bus
);

  localparam int unsigned VEC_W = calc_vec_w(NUM_BITS);
  localparam int unsigned ERR_W = calc_err_w(NUM_BITS);
  localparam int unsigned CNT_W = calc_cnt_w(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic              cnt_clear_c;
  logic              cnt_en_c;
  logic              settle_done;
  logic [NUM_BITS:0] ref_c;
  logic              mismatch_c;
  logic              stop_c;

  adder_bist_flex_counter #(
    .WIDTH (CNT_W)
  ) u_settle_cnt (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (cnt_clear_c),
    .count_enable_i  (cnt_en_c),
    .rollover_val_i  (CNT_W'(SETTLE_CYCLES - 1)),
    .rollover_flag_o (settle_done)
  );

  assign ref_c = (NUM_BITS + 1)'(adder_ref(MAX_BITS'(vec_q[NUM_BITS-1:0]),
                                           MAX_BITS'(vec_q[2*NUM_BITS-1:NUM_BITS]),
                                           vec_q[2*NUM_BITS]));
  assign mismatch_c = ({bus.carry_out_in, bus.sum_in} != ref_c);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  assign stop_c = mismatch_c;
`else
  assign stop_c = 1'b0;
`endif

  // Next state, run bookkeeping and registered status
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    err_d       = err_q;
    ffv_d       = ffv_q;
    ffvalid_d   = ffvalid_q;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        cnt_clear_c = 1'b1;
        if (bus.start) begin
          state_d   = RUN;
          vec_d     = '0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      RUN: begin
        cnt_en_c = 1'b1;
        if (settle_done) begin
          if (mismatch_c) begin
            err_d = err_q + ERR_W'(1);
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (stop_c || (vec_q == '1)) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.a_out             = vec_q[NUM_BITS-1:0];
  assign bus.b_out             = vec_q[2*NUM_BITS-1:NUM_BITS];
  assign bus.carry_in_out      = vec_q[2*NUM_BITS];
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.pass              = pass_q;
  assign bus.error_count       = err_q;
  assign bus.first_fail_vector = ffv_q;
  assign bus.first_fail_valid  = ffvalid_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: fault-injectable adder models, run table and scoreboard of expected run results.
module tb_adder_bist;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef struct {
    int         fault;
    int         cycles;
    logic [9:0] err;
    logic       ffvalid;
    logic [8:0] ffv;
    logic       pass;
    logic [8:0] last;
  } vec_t;

  logic clk;
  logic rst;
  logic start1;
  logic start2;
  int   fault1;
  int   checks;
  int   errors;
  vec_t tbl [3];
  vec_t slow_exp;
  vec_t sb_q [$];

  adder_bist_if #(.NUM_BITS(4)) bus1 ();
  adder_bist_if #(.NUM_BITS(4)) bus2 ();

  adder_bist #(.NUM_BITS(4), .SETTLE_CYCLES(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  adder_bist #(.NUM_BITS(4), .SETTLE_CYCLES(3)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  // External adder: fault 1 = sum[0] stuck at 0, fault 2 = carry_out stuck at 0
  function automatic logic [4:0] tb_adder(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin, input int fault);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + 5'(cin);
    if (fault == 1) r[0] = 1'b0;
    if (fault == 2) r[4] = 1'b0;
    return r;
  endfunction

  assign bus1.start = start1;
  assign bus2.start = start2;
  assign {bus1.carry_out_in, bus1.sum_in} = tb_adder(bus1.a_out, bus1.b_out, bus1.carry_in_out, fault1);
  assign {bus2.carry_out_in, bus2.sum_in} = tb_adder(bus2.a_out, bus2.b_out, bus2.carry_in_out, 1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse (or hold) start on one DUT, queue the expected outcome, check the cleared run state
  task automatic start_run(input int sel, input vec_t e, input bit hold);
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start1 = 1'b0;
      start2 = 1'b0;
    end
    if (sel == 1) begin
      chk("run_busy", 32'(bus1.busy), 32'd1);
      chk("run_done_clr", 32'(bus1.done), 32'd0);
      chk("run_err_clr", 32'(bus1.error_count), 32'd0);
      chk("run_ffvalid_clr", 32'(bus1.first_fail_valid), 32'd0);
      chk("run_vec0", 32'({bus1.carry_in_out, bus1.b_out, bus1.a_out}), 32'd0);
    end else begin
      chk("run2_busy", 32'(bus2.busy), 32'd1);
      chk("run2_err_clr", 32'(bus2.error_count), 32'd0);
    end
  endtask

  // Bounded wait for done, then pop the scoreboard and compare results
  task automatic wait_done(input int sel, input bit poke);
    vec_t       e;
    int         cyc;
    bit         got;
    logic [9:0] err;
    logic       ffvalid, pass, busy;
    logic [8:0] ffv, last;
    cyc = 0;
    got = 1'b0;
    while (cyc < 4000 && !got) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      got = (sel == 1) ? bus1.done : bus2.done;
      if (!got && poke) start1 = (cyc % 97 == 0);
    end
    if (poke) start1 = 1'b0;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    if (sel == 1) begin
      err = bus1.error_count; ffvalid = bus1.first_fail_valid; ffv = bus1.first_fail_vector;
      pass = bus1.pass; busy = bus1.busy; last = {bus1.carry_in_out, bus1.b_out, bus1.a_out};
    end else begin
      err = bus2.error_count; ffvalid = bus2.first_fail_valid; ffv = bus2.first_fail_vector;
      pass = bus2.pass; busy = bus2.busy; last = {bus2.carry_in_out, bus2.b_out, bus2.a_out};
    end
    chk("done_cycles", 32'(cyc), 32'(e.cycles));
    chk("error_count", 32'(err), 32'(e.err));
    chk("first_fail_valid", 32'(ffvalid), 32'(e.ffvalid));
    chk("first_fail_vector", 32'(ffv), 32'(e.ffv));
    chk("pass", 32'(pass), 32'(e.pass));
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("last_vector", 32'(last), 32'(e.last));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start1 = 1'b0;
    start2 = 1'b0;
    fault1 = 0;
    rst    = 1'b1;

    tbl[0] = '{fault: 0, cycles: 1024, err: 10'd0, ffvalid: 1'b0, ffv: 9'h000, pass: 1'b1, last: 9'h1FF};
    tbl[1] = '{fault: 1, cycles: STOP_EN ? 4 : 1024, err: STOP_EN ? 10'd1 : 10'd256,
               ffvalid: 1'b1, ffv: 9'h001, pass: 1'b0, last: STOP_EN ? 9'h001 : 9'h1FF};
    tbl[2] = '{fault: 2, cycles: STOP_EN ? 64 : 1024, err: STOP_EN ? 10'd1 : 10'd256,
               ffvalid: 1'b1, ffv: 9'h01F, pass: 1'b0, last: STOP_EN ? 9'h01F : 9'h1FF};
    slow_exp = '{fault: 1, cycles: STOP_EN ? 6 : 1536, err: STOP_EN ? 10'd1 : 10'd256,
                 ffvalid: 1'b1, ffv: 9'h001, pass: 1'b0, last: STOP_EN ? 9'h001 : 9'h1FF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_done", 32'(bus1.done), 32'd0);
    chk("rst_pass", 32'(bus1.pass), 32'd0);
    chk("rst_err", 32'(bus1.error_count), 32'd0);
    chk("rst_ff", 32'({bus1.first_fail_valid, bus1.first_fail_vector}), 32'd0);
    chk("rst_vec", 32'({bus1.carry_in_out, bus1.b_out, bus1.a_out}), 32'd0);
    rst = 1'b0;

    // Entry 0 also pokes start repeatedly mid-run; later entries restart from DONE
    for (int i = 0; i < 3; i++) begin
      fault1 = tbl[i].fault;
      start_run(1, tbl[i], 1'b0);
      wait_done(1, i == 0);
    end

    // start held high through the whole run and into DONE restarts on the next edge
    fault1 = 0;
    start_run(1, tbl[0], 1'b1);
    wait_done(1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("hold_restart_busy", 32'(bus1.busy), 32'd1);
    chk("hold_restart_done", 32'(bus1.done), 32'd0);
    chk("hold_restart_pass", 32'(bus1.pass), 32'd0);

    // Edge 300 of this run presents vector 150: a=6, b=9, cin=0; then async reset
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("mid_run_vec", 32'({bus1.carry_in_out, bus1.b_out, bus1.a_out}), 32'h096);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus1.busy), 32'd0);
    chk("async_rst_vec", 32'({bus1.carry_in_out, bus1.b_out, bus1.a_out}), 32'd0);
    chk("async_rst_status", 32'({bus1.done, bus1.pass, bus1.first_fail_valid}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_run(1, tbl[0], 1'b0);
    wait_done(1, 1'b0);

    // Three-cycle settle instance with sum[0] stuck at 0
    start_run(2, slow_exp, 1'b0);
    wait_done(2, 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
